// File: rtl/dma_ctrl_if.sv
// Pipeline-request, SRAM-port and DRAM-bus signals of dma_ctrl.
// The master modport is the controller's view; slave is the top-level/memory side.
interface dma_ctrl_if #(
  parameter int SRAM_AW = 14,
  parameter int WIDTH_W = 10
);
  logic [1:0]         dmaCmd;
  logic [31:0]        dmaSrcAddress;
  logic [31:0]        dmaDstAddress;
  logic [WIDTH_W-1:0] dmaWidth;
  logic               stall;
  logic               sramOwn;
  logic [SRAM_AW-1:0] sramAddress;
  logic               sramWriteEnable;
  logic [31:0]        sramWriteData;
  logic [31:0]        sramReadData;
  logic [31:0]        dramAddress;
  logic               dramReadReq;
  logic               dramWriteReq;
  logic [31:0]        dramWriteData;
  logic [31:0]        dramReadData;
  logic               dramAck;

  modport master (
    input  dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
    input  sramReadData, dramReadData, dramAck,
    output stall, sramOwn, sramAddress, sramWriteEnable, sramWriteData,
    output dramAddress, dramReadReq, dramWriteReq, dramWriteData
  );

  modport slave (
    output dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
    output sramReadData, dramReadData, dramAck,
    input  stall, sramOwn, sramAddress, sramWriteEnable, sramWriteData,
    input  dramAddress, dramReadReq, dramWriteReq, dramWriteData
  );
endinterface

// File: rtl/dma_ctrl.sv
// Block-transfer sequencer between DRAM and the on-chip word SRAM; stalls the pipeline while busy.
// Optional feature: define DMA_PERF_COUNTER_EN to add the busyCycles/wordsMoved counters.
module dma_ctrl #(
  parameter int SRAM_AW = 14,
  parameter int WIDTH_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  dma_ctrl_if.master  bus
`ifdef DMA_PERF_COUNTER_EN
  ,
  output logic [31:0] busyCycles,
  output logic [31:0] wordsMoved
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] D2S_RD = 3'd1;
  localparam logic [2:0] D2S_WR = 3'd2;
  localparam logic [2:0] S2D_RD = 3'd3;
  localparam logic [2:0] S2D_WR = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]         state;
  logic [29:0]        srcWord;
  logic [29:0]        dstWord;
  logic [WIDTH_W-1:0] remaining;
  logic [31:0]        dataReg;
  logic               cmdValid;
  logic               lastWord;
  logic               unusedAddrBits;

  assign cmdValid       = (bus.dmaCmd == 2'b01) || (bus.dmaCmd == 2'b10);
  assign lastWord       = (remaining == WIDTH_W'(1));
  assign unusedAddrBits = ^{bus.dmaSrcAddress[1:0], bus.dmaDstAddress[1:0]};

  // Requests are only ever consulted in IDLE; addresses wrap naturally at 2^30 words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      srcWord   <= '0;
      dstWord   <= '0;
      remaining <= '0;
      dataReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmdValid) begin
            srcWord   <= bus.dmaSrcAddress[31:2];
            dstWord   <= bus.dmaDstAddress[31:2];
            remaining <= bus.dmaWidth;
            if (bus.dmaWidth == '0)
              state <= DONE;
            else if (bus.dmaCmd == 2'b01)
              state <= D2S_RD;
            else
              state <= S2D_RD;
          end
        end
        D2S_RD: begin
          if (bus.dramAck) begin
            dataReg <= bus.dramReadData;
            state   <= D2S_WR;
          end
        end
        D2S_WR: begin
          srcWord   <= srcWord + 30'd1;
          dstWord   <= dstWord + 30'd1;
          remaining <= remaining - WIDTH_W'(1);
          state     <= lastWord ? DONE : D2S_RD;
        end
        S2D_RD: state <= S2D_WR;
        S2D_WR: begin
          if (bus.dramAck) begin
            srcWord   <= srcWord + 30'd1;
            dstWord   <= dstWord + 30'd1;
            remaining <= remaining - WIDTH_W'(1);
            state     <= lastWord ? DONE : S2D_RD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so a transfer aborts in the very cycle reset is raised.
  always_comb begin
    bus.stall           = 1'b0;
    bus.sramOwn         = 1'b0;
    bus.sramAddress     = '0;
    bus.sramWriteEnable = 1'b0;
    bus.sramWriteData   = '0;
    bus.dramAddress     = '0;
    bus.dramReadReq     = 1'b0;
    bus.dramWriteReq    = 1'b0;
    bus.dramWriteData   = '0;
    if (!reset) begin
      case (state)
        IDLE: bus.stall = cmdValid;
        D2S_RD: begin
          bus.stall       = 1'b1;
          bus.sramOwn     = 1'b1;
          bus.dramReadReq = 1'b1;
          bus.dramAddress = {srcWord, 2'b00};
        end
        D2S_WR: begin
          bus.stall           = 1'b1;
          bus.sramOwn         = 1'b1;
          bus.sramWriteEnable = 1'b1;
          bus.sramAddress     = dstWord[SRAM_AW-1:0];
          bus.sramWriteData   = dataReg;
        end
        S2D_RD: begin
          bus.stall       = 1'b1;
          bus.sramOwn     = 1'b1;
          bus.sramAddress = srcWord[SRAM_AW-1:0];
        end
        S2D_WR: begin
          bus.stall         = 1'b1;
          bus.sramOwn       = 1'b1;
          bus.sramAddress   = srcWord[SRAM_AW-1:0];
          bus.dramWriteReq  = 1'b1;
          bus.dramAddress   = {dstWord, 2'b00};
          bus.dramWriteData = bus.sramReadData;
        end
        default: ;
      endcase
    end
  end

`ifdef DMA_PERF_COUNTER_EN
  logic wordDone;
  assign wordDone = (state == D2S_WR) || ((state == S2D_WR) && bus.dramAck);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      busyCycles <= '0;
      wordsMoved <= '0;
    end else begin
      if (bus.stall && (busyCycles != 32'hFFFF_FFFF))
        busyCycles <= busyCycles + 32'd1;
      if (wordDone && (wordsMoved != 32'hFFFF_FFFF))
        wordsMoved <= wordsMoved + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed testbench for dma_ctrl with behavioural SRAM (1-cycle read) and DRAM (programmable ack latency).
module tb_dma_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_ctrl_if bus ();

`ifdef DMA_PERF_COUNTER_EN
  logic [31:0] busyCycles;
  logic [31:0] wordsMoved;
  dma_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .busyCycles(busyCycles), .wordsMoved(wordsMoved));
`else
  dma_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int checkCount = 0;
  int errorCount = 0;

  // SRAM model; the bench gets the port whenever the controller does not own it.
  logic [31:0] sramMem [0:16383];
  logic        tbSramWe = 1'b0;
  logic [13:0] tbSramAddr = '0;
  logic [31:0] tbSramData = '0;
  always @(posedge clk) begin
    if (bus.sramOwn) begin
      if (bus.sramWriteEnable) sramMem[bus.sramAddress] <= bus.sramWriteData;
      bus.sramReadData <= sramMem[bus.sramAddress];
    end else if (tbSramWe) begin
      sramMem[tbSramAddr] <= tbSramData;
    end
  end

  // DRAM model acks after ackLat extra cycles of a held request.
  logic [31:0] dramMem [0:1023];
  int          ackLat = 0;
  int          waitCnt = 0;
  logic        tbDramWe = 1'b0;
  logic [9:0]  tbDramIdx = '0;
  logic [31:0] tbDramData = '0;
  logic        reqAny;
  assign reqAny           = bus.dramReadReq | bus.dramWriteReq;
  assign bus.dramAck      = reqAny && (waitCnt == ackLat);
  assign bus.dramReadData = dramMem[bus.dramAddress[11:2]];
  always @(posedge clk) begin
    if (reqAny && !bus.dramAck) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
    if (bus.dramAck && bus.dramWriteReq) dramMem[bus.dramAddress[11:2]] <= bus.dramWriteData;
    else if (tbDramWe) dramMem[tbDramIdx] <= tbDramData;
  end

  int   reqCycles = 0;
  int   readAcks = 0;
  int   writeStrobes = 0;
  int   bothHigh = 0;
  int   dropBeforeAck = 0;
  logic prevWrPending = 1'b0;
  always @(negedge clk) begin
    if (reqAny) reqCycles++;
    if (bus.dramReadReq && bus.dramAck) readAcks++;
    if (bus.sramWriteEnable) writeStrobes++;
    if (bus.dramReadReq && bus.dramWriteReq) bothHigh++;
    if (prevWrPending && !bus.dramWriteReq) dropBeforeAck++;
    prevWrPending = bus.dramWriteReq && !bus.dramAck;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sramPoke(input logic [13:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    tbSramAddr = addr; tbSramData = data; tbSramWe = 1'b1;
    @(posedge clk); #1;
    tbSramWe = 1'b0;
  endtask

  task automatic dramPoke(input logic [9:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    tbDramIdx = idx; tbDramData = data; tbDramWe = 1'b1;
    @(posedge clk); #1;
    tbDramWe = 1'b0;
  endtask

  // Issues one request, counts stall cycles, and returns once the controller is back in IDLE.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                               input logic [9:0] width, output int stallCycles, output logic ownAtEnd);
    @(posedge clk); #1;
    bus.dmaCmd = cmd; bus.dmaSrcAddress = src; bus.dmaDstAddress = dst; bus.dmaWidth = width;
    stallCycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      stallCycles++;
      @(posedge clk); #1;
      bus.dmaCmd = 2'b00;
    end
    ownAtEnd = bus.sramOwn;
    @(posedge clk); #1;
    bus.dmaCmd = 2'b00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation timeout");
  end

  int   sc;
  logic own;
  int   snapReq, snapStrobe, snapAck;

  initial begin
    reset = 1'b1;
    bus.dmaCmd = 2'b00; bus.dmaSrcAddress = '0; bus.dmaDstAddress = '0; bus.dmaWidth = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstStall", {31'd0, bus.stall}, 32'd0);
    checkOutput("rstOwn", {31'd0, bus.sramOwn}, 32'd0);
    checkOutput("rstReqs", {30'd0, bus.dramReadReq, bus.dramWriteReq}, 32'd0);
    checkOutput("rstDramAddr", bus.dramAddress, 32'd0);
`ifdef DMA_PERF_COUNTER_EN
    checkOutput("rstBusy", busyCycles, 32'd0);
    checkOutput("rstWords", wordsMoved, 32'd0);
`endif

    // d2s, width 4, zero-latency ack
    dramPoke(10'd64, 32'd11); dramPoke(10'd65, 32'd22);
    dramPoke(10'd66, 32'd33); dramPoke(10'd67, 32'd44);
    ackLat = 0;
    snapAck = readAcks; snapStrobe = writeStrobes;
    applyStimulus(2'b01, 32'h100, 32'h40, 10'd4, sc, own);
    checkOutput("d2sStall", sc, 32'd9);
    checkOutput("d2sDoneOwn", {31'd0, own}, 32'd0);
    checkOutput("d2sSram16", sramMem[16], 32'd11);
    checkOutput("d2sSram17", sramMem[17], 32'd22);
    checkOutput("d2sSram18", sramMem[18], 32'd33);
    checkOutput("d2sSram19", sramMem[19], 32'd44);
    checkOutput("d2sReads", readAcks - snapAck, 32'd4);
    checkOutput("d2sStrobes", writeStrobes - snapStrobe, 32'd4);

    // s2d, width 3, ack two cycles after request
    sramPoke(14'd0, 32'd5); sramPoke(14'd1, 32'd6); sramPoke(14'd2, 32'd7);
    ackLat = 2;
    applyStimulus(2'b10, 32'h0, 32'h200, 10'd3, sc, own);
    checkOutput("s2dStall", sc, 32'd13);
    checkOutput("s2dDram200", dramMem[128], 32'd5);
    checkOutput("s2dDram204", dramMem[129], 32'd6);
    checkOutput("s2dDram208", dramMem[130], 32'd7);
    checkOutput("s2dHeld", dropBeforeAck, 32'd0);
`ifdef DMA_PERF_COUNTER_EN
    checkOutput("perfBusy", busyCycles, 32'd22);
    checkOutput("perfWords", wordsMoved, 32'd7);
`endif

    // width 0 and reserved command
    ackLat = 0;
    snapReq = reqCycles; snapStrobe = writeStrobes;
    applyStimulus(2'b01, 32'h100, 32'h80, 10'd0, sc, own);
    checkOutput("w0Stall", sc, 32'd1);
    checkOutput("w0Reqs", reqCycles - snapReq, 32'd0);
    checkOutput("w0Strobes", writeStrobes - snapStrobe, 32'd0);
    applyStimulus(2'b11, 32'h100, 32'h80, 10'd4, sc, own);
    checkOutput("cmd11Stall", sc, 32'd0);
    checkOutput("cmd11Reqs", reqCycles - snapReq, 32'd0);

    // reset during the third word of a width-5 d2s
    dramPoke(10'd192, 32'hA1); dramPoke(10'd193, 32'hA2); dramPoke(10'd194, 32'hA3);
    dramPoke(10'd195, 32'hA4); dramPoke(10'd196, 32'hA5);
    sramPoke(14'd66, 32'hDEAD);
    @(posedge clk); #1;
    bus.dmaCmd = 2'b01; bus.dmaSrcAddress = 32'h300; bus.dmaDstAddress = 32'h100; bus.dmaWidth = 10'd5;
    @(posedge clk); #1;
    bus.dmaCmd = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rstMidPreReq", {31'd0, bus.dramReadReq}, 32'd1);
    checkOutput("rstMidPreAddr", bus.dramAddress, 32'h308);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstMidAbort", {30'd0, bus.stall, bus.dramReadReq}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstMidCtl", {28'd0, bus.stall, bus.sramOwn, bus.sramWriteEnable, reqAny}, 32'd0);
    checkOutput("rstMidDramAddr", bus.dramAddress, 32'd0);
    checkOutput("rstMidSramAddr", {18'd0, bus.sramAddress}, 32'd0);
    checkOutput("rstMidWord1", sramMem[64], 32'hA1);
    checkOutput("rstMidWord2", sramMem[65], 32'hA2);
    checkOutput("rstMidWord3", sramMem[66], 32'hDEAD);
    applyStimulus(2'b01, 32'h300, 32'h200, 10'd1, sc, own);
    checkOutput("rstNewStall", sc, 32'd3);
    checkOutput("rstNewData", sramMem[128], 32'hA1);

    // SRAM index wrap at the top of the array
    dramPoke(10'd256, 32'hB1); dramPoke(10'd257, 32'hB2);
    applyStimulus(2'b01, 32'h400, 32'hFFFC, 10'd2, sc, own);
    checkOutput("wrapStall", sc, 32'd5);
    checkOutput("wrapTop", sramMem[16383], 32'hB1);
    checkOutput("wrapZero", sramMem[0], 32'hB2);

    checkOutput("neverBothReq", bothHigh, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
